// File: rtl/stream_capture_sink_if.sv
// Settings bus and 64-bit CHDR input stream bundled for the capture sink.
// The master side drives settings and stream data; the slave side returns i_tready.
interface stream_capture_sink_if;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [63:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;

   modport master (
      output set_stb, set_addr, set_data,
      output i_tdata, i_tlast, i_tvalid,
      input  i_tready
   );

   modport slave (
      input  set_stb, set_addr, set_data,
      input  i_tdata, i_tlast, i_tvalid,
      output i_tready
   );
endinterface

// File: rtl/stream_capture_sink.sv
// Capture sink for 64-bit CHDR packets: stores whole packets into a local RAM,
// checks each CHDR length field against the received line count, and exposes results on rb_data.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | not armed, every beat discarded
// WAIT_SOP   | armed, discarding the tail of a packet until a header arrives
// CAPTURE    | storing beats into RAM and checking packet lengths
// DONE       | limit reached; beats discarded or backpressured by hold
module stream_capture_sink #(
   parameter int BASE   = 128,
   parameter int AWIDTH = 10
) (
   input  logic                   clk,
   input  logic                   reset_n,
   stream_capture_sink_if.slave   bus,
   output logic [63:0]            rb_data,
   output logic                   armed,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_SOP = 2'd1,
      S_CAPTURE  = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [7:0]    ADDR_CTRL = 8'(BASE);
   localparam logic [7:0]    ADDR_NUM  = 8'(BASE + 1);
   localparam logic [7:0]    ADDR_RB   = 8'(BASE + 2);
   localparam int            DEPTH     = 1 << AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);

   state_t              state, state_nxt;
   logic                ctrl_wr, num_wr, rb_wr, arm_wr;
   logic                ctrl_hold;
   logic [31:0]         num_lines;
   logic [1:0]          rb_sel, sel_q;
   logic [AWIDTH-1:0]   rb_ram_addr;
   logic [AWIDTH:0]     limit, line_count, line_count_nxt;
   logic [31:0]         pkt_count;
   logic [15:0]         err_count, pkt_lines, exp_lines, cur_lines, cur_exp, hdr_exp;
   logic [16:0]         len_round;
   logic                in_pkt, trunc, beat, cap_beat, store, tready;
   logic [63:0]         mem [0:DEPTH-1];
   logic [63:0]         ram_rd, stat_q;

   assign ctrl_wr = bus.set_stb && (bus.set_addr == ADDR_CTRL);
   assign num_wr  = bus.set_stb && (bus.set_addr == ADDR_NUM);
   assign rb_wr   = bus.set_stb && (bus.set_addr == ADDR_RB);
   assign arm_wr  = ctrl_wr && bus.set_data[0];

   assign limit = ((num_lines == 32'd0) || (num_lines > 32'(DEPTH))) ? DEPTH_L
                                                                    : num_lines[AWIDTH:0];

   assign beat = bus.i_tvalid && tready;

   // A CTRL write owns the cycle: a coincident beat only moves in_pkt.
   assign cap_beat = beat && !ctrl_wr &&
                     (((state == S_WAIT_SOP) && !in_pkt) || (state == S_CAPTURE));

   assign store          = line_count < limit;
   assign line_count_nxt = line_count + {{AWIDTH{1'b0}}, store};

   // Header beat is the first beat with in_pkt low; expected lines = ceil(bytes / 8).
   assign len_round = {1'b0, bus.i_tdata[47:32]} + 17'd7;
   assign hdr_exp   = {2'b00, len_round[16:3]};
   assign cur_exp   = in_pkt ? exp_lines : hdr_exp;
   assign cur_lines = !in_pkt ? 16'd1 :
                      ((pkt_lines == 16'hFFFF) ? pkt_lines : pkt_lines + 16'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ctrl_wr)
         state_nxt = bus.set_data[0] ? S_WAIT_SOP : S_IDLE;
      else if (cap_beat)
         state_nxt = (bus.i_tlast && (line_count_nxt >= limit)) ? S_DONE : S_CAPTURE;
   end

   always_comb begin
      tready = 1'b1;
      armed  = 1'b0;
      done   = 1'b0;
      case (state)
         S_WAIT_SOP, S_CAPTURE: armed = 1'b1;
         S_DONE: begin
            done   = 1'b1;
            tready = !ctrl_hold;
         end
         default: ;
      endcase
   end

   assign bus.i_tready = tready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_hold   <= 1'b0;
         num_lines   <= '0;
         rb_sel      <= '0;
         rb_ram_addr <= '0;
         in_pkt      <= 1'b0;
         line_count  <= '0;
         pkt_count   <= '0;
         err_count   <= '0;
         pkt_lines   <= '0;
         exp_lines   <= '0;
         err         <= 1'b0;
         trunc       <= 1'b0;
      end else begin
         if (ctrl_wr) ctrl_hold <= bus.set_data[1];
         if (num_wr)  num_lines <= bus.set_data;
         if (rb_wr) begin
            rb_sel      <= bus.set_data[31:30];
            rb_ram_addr <= bus.set_data[AWIDTH-1:0];
         end
         if (beat) in_pkt <= !bus.i_tlast;

         if (arm_wr) begin
            line_count <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            pkt_lines  <= '0;
            exp_lines  <= '0;
            err        <= 1'b0;
            trunc      <= 1'b0;
         end else if (cap_beat) begin
            line_count <= line_count_nxt;
            pkt_lines  <= cur_lines;
            exp_lines  <= cur_exp;
            if (!store) trunc <= 1'b1;
            if (bus.i_tlast) begin
               pkt_count <= pkt_count + 32'd1;
               if (cur_lines != cur_exp) begin
                  err <= 1'b1;
                  if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               end
            end
         end
      end
   end

   // Kept free of reset so it maps onto block RAM; read-during-write yields the old word.
   always_ff @(posedge clk) begin
      if (cap_beat && store) mem[line_count[AWIDTH-1:0]] <= bus.i_tdata;
      ram_rd <= mem[rb_ram_addr];
   end

   // Status goes through the same two-stage path as the RAM so every select has equal latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q   <= '0;
         stat_q  <= '0;
         rb_data <= '0;
      end else begin
         sel_q <= rb_sel;
         case (rb_sel)
            2'd1:    stat_q <= {pkt_count, {(31 - AWIDTH){1'b0}}, line_count};
            2'd2:    stat_q <= {err_count, 40'b0, 2'b00, trunc, err, done, armed, state};
            default: stat_q <= '0;
         endcase
         rb_data <= (sel_q == 2'd0) ? ram_rd : stat_q;
      end
   end

endmodule

// File: tb/tb_stream_capture_sink.sv
// Directed bench for stream_capture_sink: capture, arm mid-packet, length errors,
// truncation, hold backpressure and asynchronous reset mid-capture.
module tb_stream_capture_sink;

   localparam int BASE = 128;
   localparam logic [7:0] A_CTRL = 8'(BASE);
   localparam logic [7:0] A_NUM  = 8'(BASE + 1);
   localparam logic [7:0] A_RB   = 8'(BASE + 2);

   logic        clk;
   logic        reset_n;
   logic [63:0] rb_data;
   logic        armed, done, err;
   int          n_tests = 0;
   int          n_fail  = 0;

   stream_capture_sink_if bus();

   stream_capture_sink #(.BASE(BASE), .AWIDTH(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave),
      .rb_data (rb_data),
      .armed   (armed),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pkt_word(input logic [7:0] tag, input int k,
                                            input logic [15:0] len);
      if (k == 0) return {8'hC0, tag, len, 24'h0, tag};
      return {8'hDA, tag, 16'(k), 32'h1234_5600 + 32'(k)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.set_stb  = 1'b1;
      bus.set_addr = a;
      bus.set_data = d;
      tick();
      bus.set_stb  = 1'b0;
   endtask

   task automatic rd_rb(input logic [1:0] sel, input int addr, output logic [63:0] v);
      wr(A_RB, {sel, 20'd0, 10'(addr)});
      tick();
      tick();
      v = rb_data;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic last);
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = d;
      bus.i_tlast  = last;
      tick();
      bus.i_tvalid = 1'b0;
      bus.i_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] tag, input logic [15:0] len, input int n);
      for (int k = 0; k < n; k++) send_beat(pkt_word(tag, k, len), k == n - 1);
   endtask

   task automatic test_reset();
      logic [63:0] v;
      reset_n = 1'b0;
      bus.set_stb = 0; bus.set_addr = 0; bus.set_data = 0;
      bus.i_tvalid = 0; bus.i_tlast = 0; bus.i_tdata = 0;
      repeat (2) tick();
      n_tests++; if (bus.i_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b expected 1", bus.i_tready); end
      n_tests++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b expected 0", armed); end
      n_tests++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err: got %b expected 00", {done, err}); end
      n_tests++; if (rb_data !== 64'h0) begin n_fail++; $display("FAIL reset_rb_data: got %h expected 0", rb_data); end
      reset_n = 1'b1;
      tick();
      rd_rb(2'd1, 0, v);
      n_tests++; if (v !== 64'h0) begin n_fail++; $display("FAIL reset_counters: got %h expected 0", v); end
   endtask

   task automatic test_basic();
      logic [63:0] v;
      wr(A_NUM, 32'd8);
      wr(A_CTRL, 32'd1);
      n_tests++; if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed: got %b expected 1", armed); end
      send_pkt(8'h01, 16'd32, 4);
      send_pkt(8'h02, 16'd32, 4);
      n_tests++; if ({done, armed, err} !== 3'b100) begin n_fail++; $display("FAIL basic_flags: got %b expected 100", {done, armed, err}); end
      rd_rb(2'd1, 0, v);
      n_tests++; if (v !== {32'd2, 32'd8}) begin n_fail++; $display("FAIL basic_counts: got %h expected %h", v, {32'd2, 32'd8}); end
      rd_rb(2'd2, 0, v);
      n_tests++; if (v !== 64'h0000_0000_0000_000B) begin n_fail++; $display("FAIL basic_status: got %h expected 000000000000000b", v); end
      for (int i = 0; i < 8; i++) begin
         rd_rb(2'd0, i, v);
         n_tests++;
         if (v !== pkt_word(8'(1 + i / 4), i % 4, 16'd32)) begin
            n_fail++;
            $display("FAIL basic_ram[%0d]: got %h expected %h", i, v, pkt_word(8'(1 + i / 4), i % 4, 16'd32));
         end
      end
   endtask

   task automatic test_arm_mid_pkt();
      logic [63:0] v;
      for (int k = 0; k < 3; k++) send_beat(pkt_word(8'h04, k, 16'd48), 1'b0);
      wr(A_CTRL, 32'd1);
      for (int k = 3; k < 6; k++) send_beat(pkt_word(8'h04, k, 16'd48), k == 5);
      send_pkt(8'h05, 16'd32, 4);
      rd_rb(2'd0, 0, v);
      n_tests++; if (v !== pkt_word(8'h05, 0, 16'd32)) begin n_fail++; $display("FAIL midpkt_ram0: got %h expected %h", v, pkt_word(8'h05, 0, 16'd32)); end
      rd_rb(2'd1, 0, v);
      n_tests++; if (v !== {32'd1, 32'd4}) begin n_fail++; $display("FAIL midpkt_counts: got %h expected %h", v, {32'd1, 32'd4}); end
      n_tests++; if ({armed, done, err} !== 3'b100) begin n_fail++; $display("FAIL midpkt_flags: got %b expected 100", {armed, done, err}); end
   endtask

   task automatic test_len_err();
      logic [63:0] v;
      wr(A_CTRL, 32'd1);
      send_pkt(8'h06, 16'd40, 4);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL lenerr_err: got %b expected 1", err); end
      send_pkt(8'h07, 16'd8, 1);
      rd_rb(2'd2, 0, v);
      n_tests++; if (v !== 64'h0001_0000_0000_0016) begin n_fail++; $display("FAIL lenerr_status: got %h expected 0001000000000016", v); end
      rd_rb(2'd1, 0, v);
      n_tests++; if (v !== {32'd2, 32'd5}) begin n_fail++; $display("FAIL lenerr_counts: got %h expected %h", v, {32'd2, 32'd5}); end
      rd_rb(2'd0, 4, v);
      n_tests++; if (v !== pkt_word(8'h07, 0, 16'd8)) begin n_fail++; $display("FAIL lenerr_ram4: got %h expected %h", v, pkt_word(8'h07, 0, 16'd8)); end
   endtask

   task automatic test_trunc();
      logic [63:0] v;
      wr(A_NUM, 32'd3);
      wr(A_CTRL, 32'd1);
      send_pkt(8'h08, 16'd40, 5);
      n_tests++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL trunc_flags: got %b expected 10", {done, err}); end
      rd_rb(2'd2, 0, v);
      n_tests++; if (v !== 64'h0000_0000_0000_002B) begin n_fail++; $display("FAIL trunc_status: got %h expected 000000000000002b", v); end
      rd_rb(2'd1, 0, v);
      n_tests++; if (v !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL trunc_counts: got %h expected %h", v, {32'd1, 32'd3}); end
      for (int i = 0; i < 3; i++) begin
         rd_rb(2'd0, i, v);
         n_tests++;
         if (v !== pkt_word(8'h08, i, 16'd40)) begin
            n_fail++;
            $display("FAIL trunc_ram[%0d]: got %h expected %h", i, v, pkt_word(8'h08, i, 16'd40));
         end
      end
      rd_rb(2'd0, 3, v);
      n_tests++; if (v !== pkt_word(8'h06, 3, 16'd40)) begin n_fail++; $display("FAIL trunc_ram3_kept: got %h expected %h", v, pkt_word(8'h06, 3, 16'd40)); end
   endtask

   task automatic test_hold();
      wr(A_CTRL, 32'd3);
      send_pkt(8'h09, 16'd24, 3);
      bus.i_tvalid = 1'b1;
      bus.i_tlast  = 1'b1;
      tick();
      n_tests++; if ({done, bus.i_tready} !== 2'b10) begin n_fail++; $display("FAIL hold_tready: got done,tready=%b expected 10", {done, bus.i_tready}); end
      tick();
      n_tests++; if (bus.i_tready !== 1'b0) begin n_fail++; $display("FAIL hold_tready_2: got %b expected 0", bus.i_tready); end
      wr(A_CTRL, 32'd0);
      n_tests++; if ({bus.i_tready, done, armed} !== 3'b100) begin n_fail++; $display("FAIL hold_abort: got tready,done,armed=%b expected 100", {bus.i_tready, done, armed}); end
      bus.i_tvalid = 1'b0;
      bus.i_tlast  = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [63:0] v;
      wr(A_NUM, 32'd0);
      wr(A_CTRL, 32'd1);
      send_pkt(8'h0A, 16'd16, 1);
      rd_rb(2'd1, 0, v);
      n_tests++; if ({err, v} !== {1'b1, 32'd1, 32'd1}) begin n_fail++; $display("FAIL rstmid_pre: got err=%b rb=%h expected err=1 rb=%h", err, v, {32'd1, 32'd1}); end
      for (int k = 0; k < 2; k++) send_beat(pkt_word(8'h0B, k, 16'd64), 1'b0);
      for (int k = 0; k < 4; k++) begin
         bus.i_tvalid = 1'($urandom_range(0, 1));
         bus.i_tdata  = {$urandom, $urandom};
         bus.i_tlast  = 1'b0;
         tick();
      end
      #3;
      reset_n = 1'b0;
      #1;
      n_tests++; if ({armed, done, err, bus.i_tready} !== 4'b0001) begin n_fail++; $display("FAIL rstmid_async: got armed,done,err,tready=%b expected 0001", {armed, done, err, bus.i_tready}); end
      n_tests++; if (rb_data !== 64'h0) begin n_fail++; $display("FAIL rstmid_rb: got %h expected 0", rb_data); end
      bus.i_tvalid = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      wr(A_CTRL, 32'd1);
      send_pkt(8'h0C, 16'd32, 4);
      rd_rb(2'd1, 0, v);
      n_tests++; if ({err, v} !== {1'b0, 32'd1, 32'd4}) begin n_fail++; $display("FAIL rstmid_counts: got err=%b rb=%h expected err=0 rb=%h", err, v, {32'd1, 32'd4}); end
      for (int i = 0; i < 4; i++) begin
         rd_rb(2'd0, i, v);
         n_tests++;
         if (v !== pkt_word(8'h0C, i, 16'd32)) begin
            n_fail++;
            $display("FAIL rstmid_ram[%0d]: got %h expected %h", i, v, pkt_word(8'h0C, i, 16'd32));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arm_mid_pkt();
      test_len_err();
      test_trunc();
      test_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_capture_sink.md
Name: stream_capture_sink

Overview:
- Settings-bus-controlled sink for 64-bit CHDR AXI-stream packets. It is the receive-end counterpart of the file source in the compute-engine domain.
- It sits on an RFNoC block's str_sink path, captures whole packets into an internal RAM and checks each packet's CHDR length field against its actual line count.
- Captured data, counters and status are read back over rb_data, so software or a testbench can compare them against the source's expected stream.

Parameters:
- BASE, 128, first settings register address used by this block.
- AWIDTH, 10, log2 of capture RAM depth in 64-bit lines.

Ports:
- clk  in  1  compute-engine clock.
- reset_n  in  1  asynchronous active-low reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  64  input stream data.
- i_tlast  in  1  last line of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- rb_data  out  64  readback data selected by RB_ADDR.
- armed  out  1  high in states WAIT_SOP and CAPTURE.
- done  out  1  high in state DONE.
- err  out  1  sticky: at least one length mismatch since arm.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). All state is reset on assertion and released synchronously to clk.
- Reset values:
  - State = IDLE; i_tready = 1; rb_data = 0; armed = done = err = 0.
  - All counters = 0; in_pkt = 0; NUM_LINES = 0; CTRL = 0; RB_ADDR = 0.
- Registers (written when set_stb and set_addr match):
  - BASE+0 CTRL
    - bit0 arm: write 1 clears counters and err, then goes to WAIT_SOP from any state. Write 0 goes to IDLE (abort).
    - bit1 hold: 1 means i_tready = 0 in DONE (backpressure). 0 means discard in DONE.
  - BASE+1 NUM_LINES: capture limit. Value 0 means 2^AWIDTH. Values above 2^AWIDTH are clamped to 2^AWIDTH.
  - BASE+2 RB_ADDR: [AWIDTH-1:0] RAM address; [31:30] select.
- Beat and packet tracking:
  - beat = i_tvalid && i_tready.
  - in_pkt: set on a beat with !i_tlast; cleared on a beat with i_tlast. It is tracked in every state.
- States:
  - IDLE: i_tready = 1; all beats are discarded.
  - WAIT_SOP: i_tready = 1. If in_pkt = 1 (armed mid-packet), discard until the tlast beat. The first beat with in_pkt = 0 is stored as the header, and the state moves to CAPTURE in the same cycle.
  - CAPTURE: each beat is written to RAM[line_count] while line_count < limit, and line_count increments.
    - Beats beyond the limit are counted in pkt_lines but not stored; trunc is set.
    - On a tlast beat: pkt_count increments, the length check runs, and the next state is chosen:
      - DONE if line_count has reached the limit;
      - otherwise stay in CAPTURE, where the next beat is the next header.
  - DONE: i_tready = !hold. Beats are discarded; no counter changes.
- Length check:
  - At each header beat, expected = ceil(i_tdata[47:32] / 8). This is a 16-bit byte count; 0 is treated as expected = 0.
  - At tlast, if the packet's line count (header included) differs from expected, set err and increment err_count. err_count saturates at 16 bits.
  - A single-line packet (header beat with tlast) is checked in the same cycle.
- Counters:
  - pkt_count is 32-bit and wraps.
  - line_count is AWIDTH+1 bits and never exceeds the limit.
- Readback:
  - rb_data is registered and valid exactly 2 cycles after the RB_ADDR write, or 2 cycles after any change in the selected source.
  - RAM read is synchronous and read-during-write returns old data.
  - sel 0 = RAM word.
  - sel 1 = {pkt_count[31:0], zero-extended line_count}.
  - sel 2 = {err_count[15:0], 40'b0, trunc, err, done, armed, state[1:0]}, bits [63:48], [47:8], [5], [4], [3], [2], [1:0]; bits [7:6] are 0.
  - sel 3 = 0.
- Simultaneous events:
  - A settings write takes priority over a beat in the same cycle. If arm is written while a beat occurs, that beat updates only in_pkt and is not captured.
  - Writing NUM_LINES while in CAPTURE takes effect from the next beat. If line_count is already at or above the new limit, the next tlast goes to DONE.
- Reset mid-capture: all state is cleared immediately. RAM contents are undefined.

Test Plan:
- Reset → i_tready = 1, armed = 0, rb_data = 0. NUM_LINES = 8, arm. Send 2 packets of 4 lines with headers len = 32 → DONE, pkt_count = 2, line_count = 8, err = 0. RAM[0..7] match the sent data, with readback 2 cycles after each RB_ADDR write.
- Arm while a 6-line packet is at line 3 → the remainder is discarded and capture starts at the next header. RAM[0] = the next header.
- Header len = 40 with 4 lines sent → err = 1, err_count = 1. A 1-line packet with len = 8 → no further error.
- NUM_LINES = 3, 5-line packet → RAM holds lines 0..2, trunc = 1, DONE after tlast, pkt_count = 1.
- hold = 1 in DONE → i_tready = 0 with i_tvalid held high. Write arm = 0 → i_tready = 1 the next cycle.
- Assert reset_n low mid-packet with random i_tvalid → outputs return to reset values asynchronously. Re-arm and capture a clean 4-line packet correctly.
